// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and the
// odd-parity helper used by both the host transmitter and the receiver.
package ps2_pkg;

  // Start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQUEST,
    TX_SEND,
    TX_ACK,
    TX_WAIT_IDLE,
    TX_DONE_ST,
    TX_FAIL
  } tx_state_t;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line, with a falling-edge strobe
// derived from the synchronized value and its one-cycle-delayed copy.
module ps2_line_sync (
  input  logic CLOCK,
  input  logic RESET,
  input  logic i_line,
  output logic o_sync,
  output logic o_fe
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  // Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fe   = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send handshake, frame shift-out
// on device clock falling edges, acknowledge check and timeout supervision.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int DP_size        = 8,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [DP_size-1:0] TX_DATA,
  input  logic               TX_START,
  output logic               TX_BUSY,
  output logic               TX_DONE,
  output logic               TX_ERROR,
  input  logic               SCL_IN,
  input  logic               SDA_IN,
  output logic               SCL_OE,
  output logic               SDA_OE
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  // Index of the stop bit: the fe that shifts it out ends the data phase.
  localparam logic [3:0]       STOP_IDX = 4'(PS2_FRAME_BITS - 2);

  tx_state_t          r_state;
  logic [DP_size+1:0] r_frame;
  logic [3:0]         r_bit_cnt;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [TMO_W-1:0]   r_timeout;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_scl_oe;
  logic               r_sda_oe;

  logic w_scl_sync;
  logic w_scl_fe;
  logic w_sda_sync;
  // SDA edges carry no meaning for the transmitter.
  logic w_sda_fe_unused;

  ps2_line_sync u_scl_sync (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .i_line (SCL_IN),
    .o_sync (w_scl_sync),
    .o_fe   (w_scl_fe)
  );

  ps2_line_sync u_sda_sync (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .i_line (SDA_IN),
    .o_sync (w_sda_sync),
    .o_fe   (w_sda_fe_unused)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= TX_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_timeout <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          r_scl_oe <= 1'b0;
          r_sda_oe <= 1'b0;
          r_busy   <= 1'b0;
          if (TX_START) begin
            r_frame   <= {1'b1, odd_parity(TX_DATA), TX_DATA};
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_timeout <= '0;
            r_scl_oe  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= TX_INHIBIT;
          end
        end

        TX_INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            r_sda_oe <= 1'b1;
            r_state  <= TX_REQUEST;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end

        TX_REQUEST: begin
          // Releasing SCL hands clock generation to the device; start bit stays low.
          r_scl_oe  <= 1'b0;
          r_timeout <= '0;
          r_state   <= TX_SEND;
        end

        TX_SEND, TX_ACK, TX_WAIT_IDLE: begin
          // Timeout is checked first so it wins over a coincident falling edge.
          if (r_timeout == TMO_LAST) begin
            r_scl_oe <= 1'b0;
            r_sda_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= TX_FAIL;
          end else begin
            r_timeout <= r_timeout + 1'b1;
            if (r_state == TX_SEND) begin
              if (w_scl_fe) begin
                r_sda_oe  <= ~r_frame[r_bit_cnt];
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == STOP_IDX) begin
                  r_state <= TX_ACK;
                end
              end
            end else if (r_state == TX_ACK) begin
              if (w_scl_fe) begin
                if (!w_sda_sync) begin
                  r_state <= TX_WAIT_IDLE;
                end else begin
                  r_sda_oe <= 1'b0;
                  r_error  <= 1'b1;
                  r_state  <= TX_FAIL;
                end
              end
            end else if (w_scl_sync && w_sda_sync) begin
              r_done  <= 1'b1;
              r_state <= TX_DONE_ST;
            end
          end
        end

        TX_DONE_ST: begin
          r_busy  <= 1'b0;
          r_state <= TX_IDLE;
        end

        TX_FAIL: begin
          r_scl_oe <= 1'b0;
          r_sda_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= TX_IDLE;
        end

        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign TX_BUSY  = r_busy;
  assign TX_DONE  = r_done;
  assign TX_ERROR = r_error;
  assign SCL_OE   = r_scl_oe;
  assign SDA_OE   = r_sda_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a clocking device model; frame
// bits expected at the device are queued on send and popped as it samples.
module tb_ps2_host_tx;

  localparam int INH    = 10;
  localparam int TMO    = 2000;
  localparam int PERIOD = 40;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    bit         ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_START = 1'b0;
  logic       TX_BUSY, TX_DONE, TX_ERROR;
  logic       SCL_OE, SDA_OE;
  logic       dev_scl_low = 1'b0;
  logic       dev_sda_low = 1'b0;
  logic       scl_line, sda_line;

  // Open-drain bus: either side may pull low, otherwise the pull-up wins.
  assign scl_line = ~(SCL_OE | dev_scl_low);
  assign sda_line = ~(SDA_OE | dev_sda_low);

  ps2_host_tx #(
    .DP_size        (8),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .TX_DATA  (TX_DATA),
    .TX_START (TX_START),
    .TX_BUSY  (TX_BUSY),
    .TX_DONE  (TX_DONE),
    .TX_ERROR (TX_ERROR),
    .SCL_IN   (scl_line),
    .SDA_IN   (sda_line),
    .SCL_OE   (SCL_OE),
    .SDA_OE   (SDA_OE)
  );

  always #5 CLOCK = ~CLOCK;

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   done_seen = 0;
  int   err_seen  = 0;
  logic exp_q[$];
  vec_t vecs[5];

  always @(negedge CLOCK) begin
    if (TX_DONE)  done_seen <= done_seen + 1;
    if (TX_ERROR) err_seen  <= err_seen + 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  // Returns on the first negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d);
    @(negedge CLOCK);
    TX_DATA  = d;
    TX_START = 1'b1;
    @(negedge CLOCK);
    TX_START = 1'b0;
    check("busy_on_accept", int'(TX_BUSY), 1);
    check("scl_oe_on_accept", int'(SCL_OE), 1);
  endtask

  // Device side: observe the inhibit/request phases, then clock 11 pulses.
  task automatic dev_frame(input bit do_ack, input bit do_clock, input int abort_after);
    int inh = 0;
    int req = 0;
    int guard = 0;
    while (SCL_OE && guard < 200) begin
      if (!SDA_OE) inh++;
      else req++;
      @(negedge CLOCK);
      guard++;
    end
    check("inhibit_cycles", inh, INH);
    check("request_cycles", req, 1);
    check("start_bit_line", int'(sda_line), 0);
    if (!do_clock) return;
    for (int i = 0; i < 11; i++) begin
      cycles(PERIOD / 4);
      if (i == 10 && do_ack) dev_sda_low = 1'b1;
      cycles(PERIOD / 4);
      dev_scl_low = 1'b1;
      if (abort_after == i + 1) begin
        cycles(5);
        return;
      end
      cycles(PERIOD / 2);
      dev_scl_low = 1'b0;
      if (i < 10) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
        else check($sformatf("device_bit%0d", i), int'(sda_line), int'(exp_q.pop_front()));
      end else begin
        dev_sda_low = 1'b0;
      end
    end
  endtask

  task automatic finish_frame(input int d0, input int e0, input int exp_done, input int exp_err);
    int guard = 0;
    while (TX_BUSY && guard < 200) begin
      @(negedge CLOCK);
      guard++;
    end
    check("busy_released", int'(TX_BUSY), 0);
    cycles(2);
    check("done_pulses", done_seen - d0, exp_done);
    check("error_pulses", err_seen - e0, exp_err);
    check("scl_released", int'(SCL_OE), 0);
    check("sda_released", int'(SDA_OE), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vector(input vec_t v);
    int d0, e0;
    d0 = done_seen;
    e0 = err_seen;
    push_frame(v.data, v.parity);
    send_byte(v.data);
    dev_frame(v.ack, 1'b1, 0);
    finish_frame(d0, e0, v.exp_done, v.exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0, e0, n;

    // data, odd parity bit, device acks, TX_DONE pulses, TX_ERROR pulses
    vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{8'hF4, 1'b0, 1'b1, 1, 0};

    cycles(3);
    check("reset_scl_oe", int'(SCL_OE), 0);
    check("reset_sda_oe", int'(SDA_OE), 0);
    check("reset_busy", int'(TX_BUSY), 0);
    check("reset_done", int'(TX_DONE), 0);
    check("reset_error", int'(TX_ERROR), 0);
    RESET = 1'b1;
    cycles(3);

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Device never clocks: timeout counted from the cycle SCL_OE falls.
    d0 = done_seen;
    e0 = err_seen;
    send_byte(8'h5A);
    dev_frame(1'b0, 1'b0, 0);
    n = 0;
    while (!TX_ERROR && n < TMO + 100) begin
      @(negedge CLOCK);
      n++;
    end
    check("timeout_latency", n, TMO);
    @(negedge CLOCK);
    check("busy_after_timeout", int'(TX_BUSY), 0);
    finish_frame(d0, e0, 0, 1);

    // Reset after the 4th falling edge releases both lines at once.
    push_frame(8'hA5, 1'b1);
    send_byte(8'hA5);
    dev_frame(1'b1, 1'b1, 4);
    check("sda_driven_before_reset", int'(SDA_OE), 1);
    #1 RESET = 1'b0;
    #1;
    check("reset_mid_scl_oe", int'(SCL_OE), 0);
    check("reset_mid_sda_oe", int'(SDA_OE), 0);
    check("reset_mid_busy", int'(TX_BUSY), 0);
    exp_q.delete();
    dev_scl_low = 1'b0;
    cycles(3);
    RESET = 1'b1;
    cycles(3);
    run_vector(vecs[4]);

    // TX_START during SEND must not disturb the in-flight byte.
    d0 = done_seen;
    e0 = err_seen;
    push_frame(8'hED, 1'b1);
    send_byte(8'hED);
    fork
      dev_frame(1'b1, 1'b1, 0);
      begin
        cycles(INH + 60);
        TX_DATA  = 8'hFF;
        TX_START = 1'b1;
        cycles(1);
        TX_START = 1'b0;
      end
    join
    finish_frame(d0, e0, 1, 0);
    cycles(20);
    check("no_queued_frame", int'(TX_BUSY), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
